mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares one single-port unified memory between the instruction-fetch requester and the load/store requester of the RV32I core.
- Sits between the instruction-memory and data-memory clients and the shared memory macro.
- Accepts one transaction at a time and forwards it with a registered request/ready handshake.
- Returns read data with a one-cycle acknowledge pulse to whichever requester it granted.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; must be 32 (byte enables are DW/8 = 4 bits)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; held high with i_addr stable until i_ack
- i_addr  in  AW  fetch address (word aligned)
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle
- i_rdata  out  DW  fetched word; holds value until the next fetch completes
- d_req  in  1  data request; held with d_* stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables for stores
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse on completion
- d_rdata  out  DW  load data; updated on load completion only
- m_req  out  1  memory request, registered
- m_we, m_be, m_addr, m_wdata  out  1/4/AW/DW  registered copy of the granted request
- m_ready  in  1  memory completes the transaction in the cycle it is sampled high with m_req
- m_rdata  in  DW  valid when m_ready is high
- busy  out  1  high in MEM and ACK states
- owner  out  1  1 = data requester holds the port, 0 = fetch

## Operation
- States: IDLE, MEM, ACK.
- IDLE:
  - If d_req or i_req: choose a winner and latch its address, we, be and wdata into the m_* registers.
  - For a fetch: m_we=0, m_be=4'hF.
  - Set owner and m_req=1, then go to MEM.
  - Otherwise stay in IDLE with m_req=0.
- MEM:
  - m_req and m_* are held constant.
  - On m_ready=1: capture m_rdata into i_rdata (owner=0) or d_rdata (owner=1, d_we=0 only); clear m_req; go to ACK.
- ACK:
  - Assert i_ack or d_ack according to owner for exactly this cycle, then go to IDLE.
- Default arbitration: when both requests are high in IDLE, data wins (an older instruction is blocked on it).
- Requester rule: a requester must drop or change its req no earlier than the cycle after its ack. The arbiter never re-grants a request in its ACK cycle.
- Reset (rst=0, any time, including mid-MEM):
  - state=IDLE.
  - m_req, i_ack, d_ack, busy, owner = 0.
  - m_*, i_rdata, d_rdata = 0.
  - An outstanding memory transaction is abandoned; the memory must discard it when m_req falls.

## Timing
- Request sampled in IDLE at cycle 0 → m_req=1 from cycle 1.
- m_ready sampled high at cycle k≥1 → ack high in cycle k+1 → next arbitration in cycle k+2.
- Zero-wait memory (m_ready already high in cycle 1): ack in cycle 2, with a minimum of 3 cycles per transaction.
- m_ready while m_req=0 is ignored.
- i_rdata and d_rdata are registered and stable from the ack cycle until overwritten.
- No combinational path from any input to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last-grant register (reset value = fetch) alternates the winner when both requests are high in IDLE.
  - The winner is the requester not granted last.
  - After reset, the first contended grant goes to data.
  - A single requesting client always wins regardless of history.
- Undefined: fixed data-over-fetch priority, and no last-grant register exists.

## Test plan
- Fetch only, m_ready tied high: i_req=1, i_addr=0x100, m_rdata=0x00000013 → m_req cycles 1, i_ack + i_rdata=0x00000013 in cycle 2, owner=0.
- Store with 3 wait states: d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xDEADBEEF, m_ready high at cycle 4 → m_* stable for cycles 1-4, d_ack cycle 5, d_rdata unchanged.
- Contention, macro undefined: both requests high for 3 back-to-back transactions → 3 data grants before the first fetch grant.
- Contention with ARB_ROUND_ROBIN_EN: both held high continuously → grants alternate D, I, D, I; owner toggles each transaction.
- Reset mid-MEM: rst low in cycle 2 of a load with m_ready low → m_req, busy, owner, acks all 0 immediately. After release, a new fetch completes normally with no spurious d_ack.
- Load data path: d_we=0, m_rdata=0xCAFEF00D → d_rdata=0xCAFEF00D at d_ack, i_rdata retains its previous value.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port memory, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN alternates grants under contention; default is data-over-fetch.
module mem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {StIdle, StMem, StAck} state_e;

    state_e state;
    logic   grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;  // 1 = data was granted last

    always_comb grant_d = d_req && (!i_req || !last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (state == StIdle && (d_req || i_req)) begin
            last_d <= grant_d;
        end
    end
`else
    always_comb grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= 4'h0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            busy    <= 1'b0;
            owner   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (d_req || i_req) begin
                        owner <= grant_d;
                        m_req <= 1'b1;
                        busy  <= 1'b1;
                        state <= StMem;
                        if (grant_d) begin
                            m_we    <= d_we;
                            m_be    <= d_be;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_be    <= 4'hF;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                        end
                    end
                end
                StMem: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        state <= StAck;
                        if (owner) begin
                            d_ack <= 1'b1;
                            // Stores leave the last load result untouched
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end
                end
                StAck: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
